// File: rtl/interrupt_controller_pkg.sv
// Shared register-window offsets, FSM state encodings and bus helpers
// for the memory-mapped interrupt controller.
package interrupt_controller_pkg;

  localparam logic [1:0] IC_PENDING = 2'd0;
  localparam logic [1:0] IC_MASK    = 2'd1;
  localparam logic [1:0] IC_ACK     = 2'd2;
  localparam logic [1:0] IC_CLAIM   = 2'd3;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_ASSERT  = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

  // Claim word: bit 31 flags a valid claim, low five bits carry the source id.
  function automatic logic [31:0] claim_value(input logic [4:0] id);
    return {1'b1, 26'd0, id};
  endfunction

endpackage

// File: rtl/interrupt_controller_prio_encoder.sv
// Fixed-priority encoder: reports the index of the lowest set bit of the
// active vector, so bit 0 has the highest priority.
import interrupt_controller_pkg::*;

module prio_encoder #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] active,
  output logic             valid,
  output logic [4:0]       id
);

  // Scan upward and keep the first hit.
  always_comb begin
    valid = 1'b0;
    id    = 5'd0;
    for (int i = 0; i < N_SRC; i++) begin
      if (active[i] && !valid) begin
        valid = 1'b1;
        id    = 5'(i);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller on the data-memory bus: edge-detected sources, mask,
// write-1-to-clear ACK and a claim/EOI handshake driving one CPU request.
import interrupt_controller_pkg::*;

module interrupt_controller #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hffff0080
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [31:0]      data,
  input  logic [31:0]      address,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic             InterruptRequest,
  output tri   [31:0]      ReadData,
  output logic             CtrlAddress
);

  ic_state_e        state_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] src_q_r;
  logic [4:0]       claimed_id_r;
  logic             irq_r;

  logic             hit_s;
  logic [1:0]       word_s;
  logic [N_SRC-1:0] active_s;
  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] clr_s;
  logic             valid_s;
  logic [4:0]       sel_id_s;
  logic             claim_rd_s;
  logic             eoi_match_s;
  logic [31:0]      rd_val_s;
  logic             unused_s;

  assign hit_s       = (address[31:4] == BASE_ADDR[31:4]) && (address[1:0] == 2'b00);
  assign word_s      = address[3:2];
  assign CtrlAddress = hit_s;
  assign active_s    = pending_r & mask_r;
  assign rise_s      = irq_src & ~src_q_r;
  assign claim_rd_s  = MemRead && hit_s && (word_s == IC_CLAIM);
  assign eoi_match_s = MemWrite && hit_s && (word_s == IC_CLAIM) &&
                       (state_r == IC_SERVICE) && (data[4:0] == claimed_id_r);
  assign unused_s    = ^data;

  prio_encoder #(.N_SRC(N_SRC)) u_prio (
    .active (active_s),
    .valid  (valid_s),
    .id     (sel_id_s)
  );

  // Pending bits cleared by an ACK write or a matching EOI.
  always_comb begin
    clr_s = {N_SRC{1'b0}};
    if (MemWrite && hit_s && (word_s == IC_ACK)) begin
      clr_s = data[N_SRC-1:0];
    end else if (eoi_match_s) begin
      clr_s = {{(N_SRC-1){1'b0}}, 1'b1} << claimed_id_r;
    end else begin
      clr_s = {N_SRC{1'b0}};
    end
  end

  // Edge history, pending (a new edge beats a same-cycle clear) and mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q_r   <= {N_SRC{1'b0}};
      pending_r <= {N_SRC{1'b0}};
      mask_r    <= {N_SRC{1'b0}};
    end else begin
      src_q_r   <= irq_src;
      pending_r <= (pending_r & ~clr_s) | rise_s;
      if (MemWrite && hit_s && (word_s == IC_MASK)) begin
        mask_r <= data[N_SRC-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Request FSM; the request register tracks entry into ASSERT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IC_IDLE;
      claimed_id_r <= 5'd0;
      irq_r        <= 1'b0;
    end else begin
      case (state_r)
        IC_IDLE: begin
          if (valid_s) begin
            state_r <= IC_ASSERT;
            irq_r   <= 1'b1;
          end else begin
            irq_r   <= 1'b0;
          end
        end
        IC_ASSERT: begin
          if (claim_rd_s && valid_s) begin
            state_r      <= IC_SERVICE;
            claimed_id_r <= sel_id_s;
            irq_r        <= 1'b0;
          end else if (!valid_s) begin
            state_r <= IC_IDLE;
            irq_r   <= 1'b0;
          end else begin
            irq_r   <= 1'b1;
          end
        end
        IC_SERVICE: begin
          irq_r <= 1'b0;
          if (eoi_match_s) begin
            state_r <= IC_IDLE;
          end else begin
            state_r <= IC_SERVICE;
          end
        end
        default: begin
          state_r <= IC_IDLE;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

  assign InterruptRequest = irq_r;

  // Register read mux.
  always_comb begin
    rd_val_s = 32'h0;
    case (word_s)
      IC_PENDING: rd_val_s = 32'(pending_r);
      IC_MASK:    rd_val_s = 32'(mask_r);
      IC_ACK:     rd_val_s = 32'h0;
      IC_CLAIM: begin
        if (state_r == IC_ASSERT) begin
          rd_val_s = claim_value(sel_id_s);
        end else begin
          rd_val_s = 32'h0;
        end
      end
      default:    rd_val_s = 32'h0;
    endcase
  end

  assign ReadData = (MemRead && hit_s) ? rd_val_s : {32{1'bz}};

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

  localparam logic [31:0] BASE = 32'hffff0080;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_src = 8'd0;
  logic [31:0] data = 32'd0;
  logic [31:0] address = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        InterruptRequest;
  tri   [31:0] ReadData;
  logic        CtrlAddress;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
    .clock            (clock),
    .reset            (reset),
    .irq_src          (irq_src),
    .data             (data),
    .address          (address),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .InterruptRequest (InterruptRequest),
    .ReadData         (ReadData),
    .CtrlAddress      (CtrlAddress)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address  = a;
    data     = d;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    MemRead = 1'b1;
    #1;
    check_eq(tag, ReadData, exp);
    tick();
    MemRead = 1'b0;
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check_eq(tag, {31'd0, InterruptRequest}, {31'd0, exp});
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: masked event is recorded but not requested
    check_irq("reset_irq", 1'b0);
    bus_read("reset_pending", BASE + 32'h0, 32'h0);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    tick();
    check_irq("masked_irq", 1'b0);
    bus_read("masked_pending", BASE + 32'h0, 32'h1);
    bus_write(BASE + 32'h8, 32'h1);
    bus_read("ack_cleared", BASE + 32'h0, 32'h0);

    // 2: two-cycle request latency, claim and EOI
    bus_write(BASE + 32'h4, 32'h1);
    irq_src = 8'h01;
    tick();
    check_irq("latency_t1", 1'b0);
    tick();
    check_irq("latency_t2", 1'b1);
    bus_read("claim_id0", BASE + 32'hC, 32'h80000000);
    check_irq("after_claim", 1'b0);
    irq_src = 8'h00;
    bus_write(BASE + 32'hC, 32'h0);
    tick();
    check_irq("after_eoi0", 1'b0);
    bus_read("eoi0_pending", BASE + 32'h0, 32'h0);

    // 3: priority and mismatched EOI
    bus_write(BASE + 32'h4, 32'hff);
    irq_src = 8'h28;
    tick();
    irq_src = 8'h00;
    tick();
    check_irq("two_src_irq", 1'b1);
    bus_read("claim_id3", BASE + 32'hC, 32'h80000003);
    bus_write(BASE + 32'hC, 32'h5);
    tick();
    check_irq("bad_eoi_irq", 1'b0);
    bus_read("bad_eoi_pending", BASE + 32'h0, 32'h28);
    bus_write(BASE + 32'hC, 32'h3);
    check_irq("eoi3_idle", 1'b0);
    tick();
    check_irq("eoi3_reassert", 1'b1);
    bus_read("claim_id5", BASE + 32'hC, 32'h80000005);
    bus_write(BASE + 32'hC, 32'h5);
    tick();
    check_irq("eoi5_irq", 1'b0);
    bus_read("eoi5_pending", BASE + 32'h0, 32'h0);

    // 4: ACK while asserted drops the request
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    check_irq("ack_case_assert", 1'b1);
    bus_write(BASE + 32'h8, 32'h1);
    tick();
    check_irq("ack_case_idle", 1'b0);
    bus_read("ack_case_claim", BASE + 32'hC, 32'h0);
    bus_read("ack_reads_zero", BASE + 32'h8, 32'h0);

    // 5: set wins over same-cycle ACK
    irq_src = 8'h04;
    bus_write(BASE + 32'h8, 32'h4);
    bus_read("set_wins", BASE + 32'h0, 32'h4);
    bus_read("claim_id2", BASE + 32'hC, 32'h80000002);
    irq_src = 8'h00;

    // 6: async reset during service, then window decode
    bus_read("mask_before_rst", BASE + 32'h4, 32'hff);
    reset = 1'b1;
    #2;
    check_irq("rst_irq", 1'b0);
    reset = 1'b0;
    tick();
    bus_read("rst_pending", BASE + 32'h0, 32'h0);
    bus_read("rst_mask", BASE + 32'h4, 32'h0);
    bus_read("claim_after_rst", BASE + 32'hC, 32'h0);
    bus_write(BASE + 32'h4, 32'hffffff0f);
    bus_read("mask_upper_ignored", BASE + 32'h4, 32'h0f);
    address = BASE - 32'h4;
    #1 check_eq("win_below", {31'd0, CtrlAddress}, 32'd0);
    address = BASE;
    #1 check_eq("win_base", {31'd0, CtrlAddress}, 32'd1);
    address = BASE + 32'h8;
    #1 check_eq("win_ack", {31'd0, CtrlAddress}, 32'd1);
    address = BASE + 32'hC;
    #1 check_eq("win_top", {31'd0, CtrlAddress}, 32'd1);
    address = BASE + 32'h10;
    #1 check_eq("win_above", {31'd0, CtrlAddress}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
